// File: rtl/as5401_pkg.sv
// Shared constants and types for the AS5401 bus sequencer: phase encodings,
// FSM states, address widths and return-stack depth.
package as5401_pkg;

  localparam int PC_W        = 12;
  localparam int MAR_W       = 8;
  localparam int NIB_W       = 4;
  localparam int STACK_DEPTH = 4;
  localparam int SP_W        = 2;

  localparam logic [SP_W:0] STACK_FULL = (SP_W+1)'(STACK_DEPTH);

  localparam logic [3:0] PH_FETCH  = 4'b0001;
  localparam logic [3:0] PH_DECODE = 4'b0010;
  localparam logic [3:0] PH_EXEC   = 4'b0100;
  localparam logic [3:0] PH_WB     = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EXEC  = 2'd3
  } seq_state_t;

  function automatic logic is_onehot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/as5401_bus_sequencer_if.sv
// Bus bundle between the AS5401 CPU core, program memory, data memory and the
// sequencer. The sequencer uses the master modport; the environment uses slave.
interface as5401_bus_sequencer_if;
  import as5401_pkg::*;

  logic [3:0]       phase;
  logic [NIB_W-1:0] cpu_bus;
  logic             f_write;
  logic             f_imm;
  logic             f_mar;
  logic             f_jmp;

  // Fetch handshake: prog_req stays high with prog_addr stable until a cycle
  // with prog_ack high; prog_data is taken in that same cycle, and prog_ack
  // while prog_req is low carries no meaning.
  logic [PC_W-1:0]  prog_addr;
  logic             prog_req;
  logic             prog_ack;
  logic [NIB_W-1:0] prog_data;

  logic [MAR_W-1:0] mem_addr;
  logic             mem_we;
  logic [NIB_W-1:0] mem_wdata;
  logic [NIB_W-1:0] mem_rdata;

  logic [NIB_W-1:0] cpu_din;
  logic             cpu_hold;
  seq_state_t       state;

  modport master (
    input  phase, cpu_bus, f_write, f_imm, f_mar, f_jmp,
    input  prog_ack, prog_data, mem_rdata,
    output prog_addr, prog_req, mem_addr, mem_we, mem_wdata,
    output cpu_din, cpu_hold, state
  );

  modport slave (
    output phase, cpu_bus, f_write, f_imm, f_mar, f_jmp,
    output prog_ack, prog_data, mem_rdata,
    input  prog_addr, prog_req, mem_addr, mem_we, mem_wdata,
    input  cpu_din, cpu_hold, state
  );

endinterface

// File: rtl/as5401_ret_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the
// oldest entry, and the top of an empty stack reads as zero.
module as5401_ret_stack
  import as5401_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top
);

  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_dec;
  logic [SP_W:0]   cnt;

  assign sp_dec = sp - {{(SP_W-1){1'b0}}, 1'b1};
  assign top    = (cnt == '0) ? '0 : mem[sp_dec];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[sp] <= push_data;
      sp      <= sp + {{(SP_W-1){1'b0}}, 1'b1};
      if (cnt != STACK_FULL) cnt <= cnt + {{SP_W{1'b0}}, 1'b1};
    end else if (pop && (cnt != '0)) begin
      sp  <= sp_dec;
      cnt <= cnt - {{SP_W{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/as5401_bus_sequencer.sv
// AS5401 bus sequencer: fetch handshake, MAR nibble shifting, data writes and
// PC update. Define AS5401_SEQ_CALLSTACK_EN to add the CALL/RET return stack.
module as5401_bus_sequencer
  import as5401_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  as5401_bus_sequencer_if.master bus
);

  seq_state_t       state, state_next;
  logic [PC_W-1:0]  pc, pc_target, pc_inc;
  logic [MAR_W-1:0] mar, mem_addr_q;
  logic [NIB_W-1:0] cpu_din_q, mem_wdata_q;
  logic             mem_we_q;
  logic             exec_done;
  logic             phase_ok, ack_take, ph_exec, ph_wb, ex_fire;
  logic             do_shift, do_write;
  logic             is_call, is_ret;
  logic [PC_W-1:0]  stack_top;

  assign phase_ok = is_onehot(bus.phase);
  assign ack_take = phase_ok && bus.prog_ack &&
                    ((state == ST_FETCH) || (state == ST_WAIT));
  assign ph_exec  = phase_ok && (state == ST_EXEC) && (bus.phase == PH_EXEC);
  assign ph_wb    = phase_ok && (state == ST_EXEC) && (bus.phase == PH_WB);
  // Execute actions fire once per instruction even if the CPU lingers in execute.
  assign ex_fire  = ph_exec && !exec_done;

`ifdef AS5401_SEQ_CALLSTACK_EN
  assign is_call = bus.f_jmp && bus.f_mar;
  assign is_ret  = bus.f_jmp && bus.f_write && !bus.f_mar;

  as5401_ret_stack u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (ph_wb && is_call),
    .pop       (ph_wb && is_ret),
    .push_data (pc + {{(PC_W-1){1'b0}}, 1'b1}),
    .top       (stack_top)
  );
`else
  assign is_call   = 1'b0;
  assign is_ret    = 1'b0;
  assign stack_top = '0;
`endif

  // CALL/RET reuse f_mar/f_write as qualifiers, so they must not shift or write.
  assign do_shift = ex_fire && bus.f_mar   && !(is_call || is_ret);
  assign do_write = ex_fire && bus.f_write && !(is_call || is_ret);

  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1} + {{(PC_W-1){1'b0}}, bus.f_imm};

  always_comb begin
    pc_target = pc_inc;
    if (is_ret)          pc_target = stack_top;
    else if (bus.f_jmp)  pc_target = {mar, bus.cpu_bus};
  end

  always_comb begin
    state_next   = state;
    bus.prog_req = 1'b0;
    bus.cpu_hold = 1'b0;
    case (state)
      ST_IDLE: begin
        if (phase_ok && (bus.phase == PH_FETCH)) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        bus.prog_req = 1'b1;
        if (phase_ok) state_next = bus.prog_ack ? ST_EXEC : ST_WAIT;
      end
      ST_WAIT: begin
        bus.prog_req = 1'b1;
        bus.cpu_hold = 1'b1;
        if (ack_take) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (ph_wb) state_next = ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      mar         <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_din_q   <= '0;
      exec_done   <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      // One-cycle lag means a write strobe sees the MAR before a same-cycle shift.
      mem_addr_q <= mar;
      if (ack_take)
        cpu_din_q <= bus.prog_data;
      else if ((state == ST_EXEC) && phase_ok)
        cpu_din_q <= bus.f_imm ? bus.prog_data : bus.mem_rdata;
      if (ack_take)     exec_done <= 1'b0;
      else if (ex_fire) exec_done <= 1'b1;
      if (do_write) begin
        mem_we_q    <= 1'b1;
        mem_wdata_q <= bus.cpu_bus;
      end
      if (do_shift) mar <= {mar[MAR_W-NIB_W-1:0], bus.cpu_bus};
      if (ph_wb)    pc  <= pc_target;
    end
  end

  assign bus.prog_addr = pc;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_din   = cpu_din_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_as5401_bus_sequencer.sv
// Directed bench for as5401_bus_sequencer; the return-stack scenario is built
// only when AS5401_SEQ_CALLSTACK_EN is defined.
module tb_as5401_bus_sequencer;
  import as5401_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  int               hold_cnt, req_cnt, we_cnt;
  logic             addr_moved;
  logic [PC_W-1:0]  addr_first;
  logic [MAR_W-1:0] we_addr;
  logic [NIB_W-1:0] we_data, din_fetch, din_exec;

  as5401_bus_sequencer_if bif();

  as5401_bus_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, record state-derived outputs for this cycle,
  // then advance past the next rising edge.
  task automatic step(input logic [3:0] ph, input logic ack, input logic m,
                      input logic w, input logic j, input logic im,
                      input logic [3:0] cbus);
    bif.phase    = ph;
    bif.prog_ack = ack;
    bif.f_mar    = m;
    bif.f_write  = w;
    bif.f_jmp    = j;
    bif.f_imm    = im;
    bif.cpu_bus  = cbus;
    if (bif.cpu_hold) hold_cnt++;
    if (bif.prog_req) req_cnt++;
    if (bif.prog_req && (bif.prog_addr !== addr_first)) addr_moved = 1'b1;
    if (bif.mem_we) begin
      we_cnt++;
      we_addr = bif.mem_addr;
      we_data = bif.mem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic m, input logic w, input logic j, input logic im,
                          input logic [3:0] bus_ex, input logic [3:0] bus_wb,
                          input int ack_wait);
    hold_cnt   = 0;
    req_cnt    = 0;
    we_cnt     = 0;
    addr_moved = 1'b0;
    addr_first = bif.prog_addr;
    for (int i = 0; i < ack_wait; i++) step(PH_FETCH, 1'b0, 0, 0, 0, 0, 4'h0);
    step(PH_FETCH, 1'b1, 0, 0, 0, 0, 4'h0);
    din_fetch = bif.cpu_din;
    step(PH_DECODE, 1'b0, 0, 0, 0, 0, 4'h0);
    din_exec = bif.cpu_din;
    step(PH_EXEC, 1'b0, m, w, j, im, bus_ex);
    step(PH_WB, 1'b0, m, w, j, im, bus_wb);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(4'b0000, 1'b0, 0, 0, 0, 0, 4'h0);
    step(4'b0000, 1'b0, 0, 0, 0, 0, 4'h0);
    n_checks++; if (bif.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bif.state, ST_IDLE); end
    n_checks++; if (bif.prog_addr !== 12'h000) begin n_fail++; $display("FAIL reset_pc: got %h expected 000", bif.prog_addr); end
    n_checks++; if (bif.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mar: got %h expected 00", bif.mem_addr); end
    n_checks++; if (bif.prog_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bif.prog_req); end
    n_checks++; if (bif.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bif.mem_we); end
    n_checks++; if (bif.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0", bif.cpu_hold); end
    n_checks++; if (bif.cpu_din !== 4'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 0", bif.cpu_din); end
    rst = 1'b0;
    step(4'b0010, 1'b0, 0, 0, 0, 0, 4'h0);
    n_checks++; if (bif.state !== ST_IDLE) begin n_fail++; $display("FAIL idle_wait: got %0d expected %0d", bif.state, ST_IDLE); end
    step(PH_FETCH, 1'b0, 0, 0, 0, 0, 4'h0);
    n_checks++; if (bif.state !== ST_FETCH) begin n_fail++; $display("FAIL idle_to_fetch: got %0d expected %0d", bif.state, ST_FETCH); end
    n_checks++; if (bif.prog_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req: got %b expected 1", bif.prog_req); end
  endtask

  task automatic test_basic();
    bif.prog_data = 4'h9;
    bif.mem_rdata = 4'h6;
    do_instr(0, 0, 0, 0, 4'h0, 4'h0, 0);
    n_checks++; if (addr_first !== 12'h000) begin n_fail++; $display("FAIL basic_addr0: got %h expected 000", addr_first); end
    n_checks++; if (hold_cnt !== 0) begin n_fail++; $display("FAIL basic_hold: got %0d expected 0", hold_cnt); end
    n_checks++; if (req_cnt !== 1) begin n_fail++; $display("FAIL basic_req: got %0d expected 1", req_cnt); end
    n_checks++; if (din_fetch !== 4'h9) begin n_fail++; $display("FAIL basic_din_fetch: got %h expected 9", din_fetch); end
    n_checks++; if (din_exec !== 4'h6) begin n_fail++; $display("FAIL basic_din_rdata: got %h expected 6", din_exec); end
    n_checks++; if (bif.prog_addr !== 12'h001) begin n_fail++; $display("FAIL basic_addr1: got %h expected 001", bif.prog_addr); end
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL basic_we: got %0d expected 0", we_cnt); end
  endtask

  task automatic test_wait();
    do_instr(0, 0, 0, 0, 4'h0, 4'h0, 3);
    n_checks++; if (addr_first !== 12'h001) begin n_fail++; $display("FAIL wait_addr: got %h expected 001", addr_first); end
    n_checks++; if (hold_cnt !== 3) begin n_fail++; $display("FAIL wait_hold: got %0d expected 3", hold_cnt); end
    n_checks++; if (req_cnt !== 4) begin n_fail++; $display("FAIL wait_req: got %0d expected 4", req_cnt); end
    n_checks++; if (addr_moved !== 1'b0) begin n_fail++; $display("FAIL wait_pc_stable: got %b expected 0", addr_moved); end
    n_checks++; if (bif.prog_addr !== 12'h002) begin n_fail++; $display("FAIL wait_next: got %h expected 002", bif.prog_addr); end
  endtask

  task automatic test_mar_write();
    do_instr(1, 0, 0, 0, 4'hA, 4'h0, 0);
    do_instr(1, 0, 0, 0, 4'h5, 4'h0, 0);
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL mar_no_we: got %0d expected 0", we_cnt); end
    do_instr(0, 1, 0, 0, 4'h3, 4'h0, 0);
    n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL write_pulses: got %0d expected 1", we_cnt); end
    n_checks++; if (we_addr !== 8'hA5) begin n_fail++; $display("FAIL write_addr: got %h expected a5", we_addr); end
    n_checks++; if (we_data !== 4'h3) begin n_fail++; $display("FAIL write_data: got %h expected 3", we_data); end
    n_checks++; if (bif.prog_addr !== 12'h005) begin n_fail++; $display("FAIL write_pc: got %h expected 005", bif.prog_addr); end
  endtask

  task automatic test_jump_wrap();
    do_instr(1, 0, 0, 0, 4'h1, 4'h0, 0);
    do_instr(1, 0, 0, 0, 4'h2, 4'h0, 0);
    do_instr(0, 0, 1, 0, 4'h0, 4'h7, 0);
    n_checks++; if (bif.prog_addr !== 12'h127) begin n_fail++; $display("FAIL jump_127: got %h expected 127", bif.prog_addr); end
    do_instr(1, 0, 0, 0, 4'hF, 4'h0, 0);
    do_instr(1, 0, 0, 0, 4'hF, 4'h0, 0);
    do_instr(0, 0, 1, 1, 4'h0, 4'hF, 0);
    n_checks++; if (bif.prog_addr !== 12'hFFF) begin n_fail++; $display("FAIL jump_imm_prio: got %h expected fff", bif.prog_addr); end
    do_instr(0, 0, 0, 1, 4'h0, 4'h0, 0);
    n_checks++; if (bif.prog_addr !== 12'h001) begin n_fail++; $display("FAIL wrap_imm: got %h expected 001", bif.prog_addr); end
    do_instr(0, 0, 1, 0, 4'h0, 4'hF, 0);
    do_instr(0, 0, 0, 0, 4'h0, 4'h0, 0);
    n_checks++; if (bif.prog_addr !== 12'h000) begin n_fail++; $display("FAIL wrap_plain: got %h expected 000", bif.prog_addr); end
  endtask

  task automatic test_invalid_phase();
    we_cnt = 0;
    step(4'b0011, 1'b1, 0, 0, 0, 0, 4'h0);
    n_checks++; if (bif.state !== ST_FETCH) begin n_fail++; $display("FAIL inv_fetch_state: got %0d expected %0d", bif.state, ST_FETCH); end
    step(PH_FETCH, 1'b1, 0, 0, 0, 0, 4'h0);
    step(PH_DECODE, 1'b0, 0, 0, 0, 0, 4'h0);
    step(4'b0110, 1'b0, 1, 1, 0, 0, 4'h3);
    step(4'b0000, 1'b0, 1, 1, 0, 0, 4'h3);
    n_checks++; if (bif.state !== ST_EXEC) begin n_fail++; $display("FAIL inv_exec_state: got %0d expected %0d", bif.state, ST_EXEC); end
    step(PH_EXEC, 1'b0, 0, 0, 0, 0, 4'h0);
    step(PH_WB, 1'b0, 0, 0, 0, 0, 4'h0);
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL inv_no_we: got %0d expected 0", we_cnt); end
    n_checks++; if (bif.mem_addr !== 8'hFF) begin n_fail++; $display("FAIL inv_mar: got %h expected ff", bif.mem_addr); end
    n_checks++; if (bif.prog_addr !== 12'h001) begin n_fail++; $display("FAIL inv_pc: got %h expected 001", bif.prog_addr); end
  endtask

  task automatic test_mar_and_write();
    do_instr(1, 1, 0, 0, 4'hC, 4'h0, 0);
    n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL both_pulses: got %0d expected 1", we_cnt); end
    n_checks++; if (we_addr !== 8'hFF) begin n_fail++; $display("FAIL both_preshift_addr: got %h expected ff", we_addr); end
    n_checks++; if (we_data !== 4'hC) begin n_fail++; $display("FAIL both_data: got %h expected c", we_data); end
    do_instr(0, 1, 0, 0, 4'h1, 4'h0, 0);
    n_checks++; if (we_addr !== 8'hFC) begin n_fail++; $display("FAIL both_postshift_addr: got %h expected fc", we_addr); end
    n_checks++; if (bif.prog_addr !== 12'h003) begin n_fail++; $display("FAIL both_pc: got %h expected 003", bif.prog_addr); end
  endtask

`ifdef AS5401_SEQ_CALLSTACK_EN
  task automatic test_callstack();
    logic [PC_W-1:0] exp_ret [5];
    exp_ret[0] = 12'h205; exp_ret[1] = 12'h204; exp_ret[2] = 12'h203;
    exp_ret[3] = 12'h202; exp_ret[4] = 12'h000;
    do_instr(1, 0, 0, 0, 4'h0, 4'h0, 0);
    do_instr(1, 0, 0, 0, 4'h3, 4'h0, 0);
    do_instr(0, 0, 1, 0, 4'h0, 4'hE, 0);
    do_instr(1, 0, 0, 0, 4'h2, 4'h0, 0);
    do_instr(1, 0, 0, 0, 4'h0, 4'h0, 0);
    n_checks++; if (bif.prog_addr !== 12'h040) begin n_fail++; $display("FAIL call_setup: got %h expected 040", bif.prog_addr); end
    do_instr(1, 0, 1, 0, 4'h9, 4'h0, 0);
    n_checks++; if (bif.prog_addr !== 12'h200) begin n_fail++; $display("FAIL call_target: got %h expected 200", bif.prog_addr); end
    do_instr(0, 1, 1, 0, 4'h9, 4'h0, 0);
    n_checks++; if (bif.prog_addr !== 12'h041) begin n_fail++; $display("FAIL ret_target: got %h expected 041", bif.prog_addr); end
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL ret_no_we: got %0d expected 0", we_cnt); end
    for (int i = 1; i <= 5; i++) begin
      do_instr(1, 0, 1, 0, 4'h0, 4'(i), 0);
      n_checks++; if (bif.prog_addr !== (12'h200 + 12'(i))) begin n_fail++; $display("FAIL call_%0d: got %h expected %h", i, bif.prog_addr, 12'h200 + 12'(i)); end
    end
    for (int i = 0; i < 5; i++) begin
      do_instr(0, 1, 1, 0, 4'h0, 4'h0, 0);
      n_checks++; if (bif.prog_addr !== exp_ret[i]) begin n_fail++; $display("FAIL ret_%0d: got %h expected %h", i, bif.prog_addr, exp_ret[i]); end
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    we_cnt = 0;
    step(PH_FETCH, 1'b0, 0, 0, 0, 0, 4'h0);
    n_checks++; if (bif.state !== ST_WAIT) begin n_fail++; $display("FAIL rstw_enter_wait: got %0d expected %0d", bif.state, ST_WAIT); end
    rst = 1'b1;
    step(PH_EXEC, 1'b0, 0, 1, 0, 0, 4'h7);
    rst = 1'b0;
    step(PH_EXEC, 1'b1, 0, 1, 0, 0, 4'h7);
    if (bif.mem_we) we_cnt++;
    n_checks++; if (bif.state !== ST_IDLE) begin n_fail++; $display("FAIL rstw_state: got %0d expected %0d", bif.state, ST_IDLE); end
    n_checks++; if (bif.prog_addr !== 12'h000) begin n_fail++; $display("FAIL rstw_pc: got %h expected 000", bif.prog_addr); end
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rstw_no_we: got %0d expected 0", we_cnt); end
    n_checks++; if (bif.prog_req !== 1'b0) begin n_fail++; $display("FAIL rstw_req: got %b expected 0", bif.prog_req); end
    n_checks++; if (bif.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL rstw_hold: got %b expected 0", bif.cpu_hold); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    addr_first    = '0;
    bif.phase     = 4'b0000;
    bif.cpu_bus   = 4'h0;
    bif.f_write   = 1'b0;
    bif.f_imm     = 1'b0;
    bif.f_mar     = 1'b0;
    bif.f_jmp     = 1'b0;
    bif.prog_ack  = 1'b0;
    bif.prog_data = 4'h0;
    bif.mem_rdata = 4'h0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_wait();
    test_mar_write();
    test_jump_wrap();
    test_invalid_phase();
    test_mar_and_write();
`ifdef AS5401_SEQ_CALLSTACK_EN
    test_callstack();
`endif
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
